// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
// Purpose : bundles the instruction-memory request bus, the decode handshake,
//           the execute redirect and the queue occupancy of the fetch buffer.
// Signals :
//   imem_req/imem_addr   request to instruction memory (held until imem_ack)
//   imem_ack/imem_data   response; ack may come in the same cycle as req
//   id_valid/id_instr/id_pc  queue head offered to decode
//   id_ready             decode accepts the head
//   redirect/redirect_pc flush and restart request from execute
//   count                number of valid queue entries
// Modports:
//   master - the fetch buffer itself
//   slave  - memory/decode/execute environment
// -----------------------------------------------------------------------------
interface fetch_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_data;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_instr;
    logic [31:0]   id_pc;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, count,
        input  imem_ack, imem_data, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, count,
        output imem_ack, imem_data, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Purpose : sequential instruction prefetcher. Issues one word-aligned read at
//           a time to instruction memory, queues {pc, instr} pairs in a DEPTH
//           entry circular buffer and offers the head to decode. A redirect
//           flushes the queue and restarts fetching at redirect_pc; a request
//           already on the bus is never withdrawn, its response is dropped.
// Ports   :
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset
//   bus    - fetch_buffer_if.master (memory bus, decode handshake, redirect,
//            occupancy count)
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    // IDLE: no request; BUSY: request for fetch_pc; DRAIN: old request still
    // on the bus after a redirect, its data will be dropped.
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          valid;
    logic          pop;
    logic          push;
    logic [31:0]   redirect_addr;

    assign redirect_addr = {bus.redirect_pc[31:2], 2'b00};

    // A redirect hides the head in the same cycle so nothing stale reaches decode.
    assign valid = (count_q != '0) && !bus.redirect;
    assign pop   = valid && bus.id_ready;

    // Only a live (non-draining) response is enqueued, and only if there is
    // room now or a slot frees this same cycle.
    assign push  = (state_q == BUSY) && bus.imem_ack && !bus.redirect &&
                   ((count_q != FULL) || pop);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (bus.redirect) begin
            fetch_pc_d = redirect_addr;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end

        unique case (state_q)
            IDLE: begin
                // Queue is full here; restart as soon as a slot opens or the
                // queue is flushed.
                if (bus.redirect || (count_q != FULL) || pop) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.redirect && !bus.imem_ack) begin
                    // Keep presenting the old address until memory answers.
                    state_d      = DRAIN;
                    drain_addr_d = fetch_pc_q;
                end else if (push && !pop && (count_q == ALMOST)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    state_d = BUSY;
                end
            end
            default: state_d = BUSY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BUSY;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage and the drain address carry no reset: they are only read when
    // count/state say they are meaningful.
    always_ff @(posedge clk) begin
        drain_addr_q <= drain_addr_d;
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= bus.imem_data;
        end
    end

    assign bus.imem_req  = (state_q != IDLE);
    assign bus.imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign bus.id_valid  = valid;
    assign bus.id_instr  = instr_mem[head_q];
    assign bus.id_pc     = pc_mem[head_q];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    logic [31:0] salt;
    int          lat;
    logic        rand_mode;
    logic        rnd_ack;
    int          wait_q;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    always @(posedge clk) begin
        if (reset || !bus.imem_req || bus.imem_ack) wait_q <= 0;
        else wait_q <= wait_q + 1;
    end

    assign bus.imem_ack  = bus.imem_req && (rand_mode ? rnd_ack : (wait_q >= lat));
    assign bus.imem_data = (bus.imem_addr * 32'h9E37_79B1) ^ salt;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready = 1'b1;
        lat = 0;
        @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RESET_PC); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        bus.id_ready = 1'b1;
        lat = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            e = RESET_PC + 32'(4 * k);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== e) begin
                errors++; $display("FAIL stream_addr k=%0d: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, e);
            end
            if (k == 0) begin
                checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", bus.id_valid); end
            end else begin
                e = e - 32'd4;
                checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== instr_of(e)) begin
                    errors++; $display("FAIL stream_head k=%0d: got v=%b pc=%h in=%h want v=1 pc=%h in=%h", k, bus.id_valid, bus.id_pc, bus.id_instr, e, instr_of(e));
                end
            end
        end
    endtask

    task automatic test_full();
        bus.id_ready = 1'b0;
        lat = 0;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k) || bus.count !== 3'(k)) begin
                errors++; $display("FAIL full_fill k=%0d: got req=%b addr=%h cnt=%0d want req=1 addr=%h cnt=%0d", k, bus.imem_req, bus.imem_addr, bus.count, 4 * k, k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.imem_req !== 1'b0 || bus.count !== 3'd4) begin
                errors++; $display("FAIL full_idle k=%0d: got req=%b cnt=%0d want req=0 cnt=4", k, bus.imem_req, bus.count);
            end
        end
        @(negedge clk); bus.id_ready = 1'b1; #1;
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL full_pop: got v=%b pc=%h req=%b want v=1 pc=0 req=0", bus.id_valid, bus.id_pc, bus.imem_req);
        end
        @(negedge clk); bus.id_ready = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.count !== 3'd3 || bus.id_pc !== 32'h4) begin
            errors++; $display("FAIL full_refetch: got req=%b addr=%h cnt=%0d pc=%h want req=1 addr=10 cnt=3 pc=4", bus.imem_req, bus.imem_addr, bus.count, bus.id_pc);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.imem_req !== 1'b0 || bus.count !== 3'd4) begin
                errors++; $display("FAIL full_after k=%0d: got req=%b cnt=%0d want req=0 cnt=4", k, bus.imem_req, bus.count);
            end
        end
    endtask

    task automatic test_drain();
        logic found;
        logic acked;
        logic seen;
        bus.id_ready = 1'b1;
        lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL drain_issue8: got no request for 8 want one"); end
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'h40; #1;
        checks++; if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1 || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL drain_redirect: got req=%b addr=%h v=%b want req=1 addr=8 v=0", bus.imem_req, bus.imem_addr, bus.id_valid);
        end
        acked = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clk); bus.redirect = 1'b0; #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.id_valid !== 1'b0) begin
                errors++; $display("FAIL drain_hold i=%0d: got req=%b addr=%h v=%b want req=1 addr=8 v=0", i, bus.imem_req, bus.imem_addr, bus.id_valid);
            end
            if (bus.imem_ack) acked = 1'b1;
        end
        checks++; if (!acked) begin errors++; $display("FAIL drain_ack: got no ack want ack"); end
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            errors++; $display("FAIL drain_next: got req=%b addr=%h want req=1 addr=40", bus.imem_req, bus.imem_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.id_valid) begin
                seen = 1'b1;
                checks++; if (bus.id_pc !== 32'h40 || bus.id_instr !== instr_of(32'h40)) begin
                    errors++; $display("FAIL drain_first_pc: got pc=%h in=%h want pc=40 in=%h", bus.id_pc, bus.id_instr, instr_of(32'h40));
                end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL drain_timeout: got no id_valid want 1"); end
    endtask

    task automatic test_redirect_ack();
        logic hit;
        logic seen;
        bus.id_ready = 1'b0;
        lat = 2;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            if (bus.imem_req && bus.imem_ack && bus.imem_addr == 32'hC) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rack_find: got no ack for C want one"); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100; #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rack_valid: got %b want 0", bus.id_valid); end
        @(negedge clk); bus.redirect = 1'b0; #1;
        checks++; if (bus.count !== 3'd0 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1 || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL rack_after: got cnt=%0d addr=%h req=%b v=%b want cnt=0 addr=100 req=1 v=0", bus.count, bus.imem_addr, bus.imem_req, bus.id_valid);
        end
        bus.id_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.id_valid) begin
                seen = 1'b1;
                checks++; if (bus.id_pc !== 32'h100 || bus.id_instr !== instr_of(32'h100)) begin
                    errors++; $display("FAIL rack_first_pc: got pc=%h in=%h want pc=100 in=%h", bus.id_pc, bus.id_instr, instr_of(32'h100));
                end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rack_timeout: got no id_valid want 1"); end
    endtask

    task automatic test_wrap();
        bus.id_ready = 1'b1;
        lat = 0;
        do_reset();
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; #1;
        @(negedge clk); bus.redirect = 1'b0; #1;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_issue: got addr=%h v=%b want addr=fffffffc v=0", bus.imem_addr, bus.id_valid);
        end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b1 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_instr !== instr_of(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_zero: got addr=%h v=%b pc=%h want addr=0 v=1 pc=fffffffc", bus.imem_addr, bus.id_valid, bus.id_pc);
        end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h4 || bus.id_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got addr=%h pc=%h want addr=4 pc=0", bus.imem_addr, bus.id_pc);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        logic seen;
        bus.id_ready = 1'b0;
        lat = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            if (bus.count == 3'd3 && bus.imem_req && !bus.imem_ack) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_setup: got cnt=%0d want 3 with pending request", bus.count); end
        #1; reset = 1'b1; #1;
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            errors++; $display("FAIL rmid_async: got cnt=%0d v=%b req=%b addr=%h want cnt=0 v=0 req=1 addr=%h", bus.count, bus.id_valid, bus.imem_req, bus.imem_addr, RESET_PC);
        end
        @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.count !== 3'd0) begin
            errors++; $display("FAIL rmid_release: got req=%b addr=%h cnt=%0d want req=1 addr=%h cnt=0", bus.imem_req, bus.imem_addr, bus.count, RESET_PC);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.id_valid) begin
                seen = 1'b1;
                checks++; if (bus.id_pc !== RESET_PC || bus.count !== 3'd1) begin
                    errors++; $display("FAIL rmid_first: got pc=%h cnt=%0d want pc=%h cnt=1", bus.id_pc, bus.count, RESET_PC);
                end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_timeout: got no id_valid want 1"); end
    endtask

    // The reference view: decode must see consecutive word addresses starting
    // at the latest restart point, each paired with that address's memory word.
    task automatic test_random(input int n);
        logic [31:0] exp_pc;
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic        exp_valid;
        rand_mode = 1'b1;
        rnd_ack = 1'b0;
        bus.id_ready = 1'b0;
        do_reset();
        exp_pc = RESET_PC;
        prev_pend = bus.imem_req && !bus.imem_ack;
        prev_addr = bus.imem_addr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.id_ready = ($urandom_range(0, 3) != 0);
            rnd_ack = ($urandom_range(0, 2) != 0);
            bus.redirect = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            #1;
            exp_valid = (bus.count != 3'd0) && !bus.redirect;
            checks++; if (bus.id_valid !== exp_valid || bus.count > 3'(DEPTH)) begin
                errors++; $display("FAIL rnd_valid i=%0d: got v=%b cnt=%0d want v=%b cnt<=%0d", i, bus.id_valid, bus.count, exp_valid, DEPTH);
            end
            if (prev_pend) begin
                checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_hold i=%0d: got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, prev_addr);
                end
            end
            if (bus.id_valid && bus.id_ready) begin
                checks++; if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL rnd_pop i=%0d: got pc=%h in=%h want pc=%h in=%h", i, bus.id_pc, bus.id_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (bus.redirect) exp_pc = {bus.redirect_pc[31:2], 2'b00};
            prev_pend = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        rand_mode = 1'b0;
    endtask

    initial begin
        salt = $urandom;
        rand_mode = 1'b0;
        rnd_ack = 1'b0;
        lat = 0;
        reset = 1'b1;
        bus.id_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
